// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised vending-machine controller (N products, change, refund)
// Optional BCD_DISPLAY_EN adds registered two-digit 7-segment credit/change outputs.
module vend_ctrl_param #(
  parameter int NUM_PROD = 4,
  parameter int COIN_W = 3,
  parameter int CREDIT_W = 7,
  parameter logic [NUM_PROD*CREDIT_W-1:0] PRICE_LIST = {7'd5, 7'd4, 7'd3, 7'd2},
  parameter int TIMEOUT_CYC = 1000,
  parameter int DELIVER_CYC = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_PROD-1:0] sel,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_val,
  input  logic                cancel,
  output logic [NUM_PROD-1:0] product,
  output logic                delivered,
  output logic [NUM_PROD-1:0] sel_led,
  output logic [CREDIT_W-1:0] credit,
  output logic [CREDIT_W-1:0] change,
  output logic                change_valid,
  output logic                coin_reject,
  output logic                busy
`ifdef BCD_DISPLAY_EN
  ,
  output logic [13:0]         seg_credit,
  output logic [13:0]         seg_change
`endif
);

  localparam int IW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int DW = $clog2(DELIVER_CYC + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DELIVER, REFUND} state_t;

  state_t              state, state_nx;
  logic [IW-1:0]       idx, idx_nx, sel_idx;
  logic [CREDIT_W-1:0] credit_nx, change_nx, sum, price;
  logic [CREDIT_W:0]   wide_sum;
  logic [NUM_PROD-1:0] sel_led_nx;
  logic [TW-1:0]       tmr, tmr_nx;
  logic [DW-1:0]       dcnt, dcnt_nx;
  logic                change_valid_nx, coin_reject_nx;
  logic                coin_nz, coin_ok, sel_one;

  assign coin_nz  = coin_valid && (coin_val != '0);
  assign wide_sum = {1'b0, credit} + (CREDIT_W+1)'(coin_val);
  assign coin_ok  = coin_nz && !wide_sum[CREDIT_W];
  assign sum      = coin_ok ? wide_sum[CREDIT_W-1:0] : credit;
  assign sel_one  = (sel != '0) && ((sel & (sel - 1'b1)) == '0);

  assign delivered = (state == DELIVER);
  assign busy      = (state != IDLE);

  always_comb begin
    price   = '0;
    sel_idx = '0;
    product = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      if (idx == IW'(i)) price = PRICE_LIST[i*CREDIT_W +: CREDIT_W];
      if (sel[i]) sel_idx = IW'(i);
      if (state == DELIVER && idx == IW'(i)) product[i] = 1'b1;
    end
  end

  always_comb begin
    state_nx        = state;
    idx_nx          = idx;
    credit_nx       = credit;
    change_nx       = change;
    change_valid_nx = 1'b0;
    coin_reject_nx  = 1'b0;
    sel_led_nx      = sel_led;
    tmr_nx          = tmr;
    dcnt_nx         = dcnt;
    case (state)
      IDLE: begin
        coin_reject_nx = coin_nz;
        if (sel_one) begin
          idx_nx     = sel_idx;
          sel_led_nx = sel;
          change_nx  = '0;
          tmr_nx     = '0;
          state_nx   = COLLECT;
        end
      end
      COLLECT: begin
        // Cancel wins over both a coin and a price match in the same cycle.
        if (cancel) begin
          coin_reject_nx  = coin_nz;
          change_nx       = credit;
          change_valid_nx = 1'b1;
          state_nx        = REFUND;
        end else begin
          coin_reject_nx = coin_nz && !coin_ok;
          credit_nx      = sum;
          tmr_nx         = coin_ok ? '0 : tmr + 1'b1;
          if (sum >= price) begin
            change_nx       = sum - price;
            change_valid_nx = 1'b1;
            dcnt_nx         = '0;
            state_nx        = DELIVER;
          end else if (!coin_ok && tmr == TW'(TIMEOUT_CYC - 1)) begin
            change_nx       = credit;
            change_valid_nx = 1'b1;
            state_nx        = REFUND;
          end
        end
      end
      DELIVER: begin
        coin_reject_nx = coin_nz;
        if (dcnt == DW'(DELIVER_CYC - 1)) begin
          credit_nx  = '0;
          sel_led_nx = '0;
          state_nx   = IDLE;
        end else begin
          dcnt_nx = dcnt + 1'b1;
        end
      end
      default: begin
        coin_reject_nx = coin_nz;
        credit_nx      = '0;
        sel_led_nx     = '0;
        state_nx       = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      credit       <= '0;
      change       <= '0;
      change_valid <= 1'b0;
      coin_reject  <= 1'b0;
      sel_led      <= '0;
      tmr          <= '0;
      dcnt         <= '0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      credit       <= credit_nx;
      change       <= change_nx;
      change_valid <= change_valid_nx;
      coin_reject  <= coin_reject_nx;
      sel_led      <= sel_led_nx;
      tmr          <= tmr_nx;
      dcnt         <= dcnt_nx;
    end
  end

`ifdef BCD_DISPLAY_EN
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b1000000;
    endcase
  endfunction

  // Values above 99 show a dash on both digits.
  function automatic logic [13:0] seg2(input logic [CREDIT_W-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    if (w > 32'd99) seg2 = {7'b1000000, 7'b1000000};
    else            seg2 = {seg7(4'(w / 32'd10)), seg7(4'(w % 32'd10))};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_credit <= {7'b0111111, 7'b0111111};
      seg_change <= {7'b0111111, 7'b0111111};
    end else begin
      seg_credit <= seg2(credit);
      seg_change <= seg2(change);
    end
  end
`endif

endmodule
